// File: rtl/ml_frame_pkg.sv
// Shared definitions for the ML-side frame receiver: parameter defaults and
// FSM state encodings.
package ml_frame_pkg;

    localparam int FRAME_WORDS_DEF = 1024;
    localparam int AW_DEF          = 16;
    localparam int DW_DEF          = 16;
    localparam int TIMEOUT_DEF     = 4095;

    // FSM state encodings
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READY = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;
    localparam logic [2:0] ABORT = 3'd5;

endpackage

// File: rtl/ml_frame_buf_dpram.sv
// Frame buffer: DEPTH x DW simple dual-port RAM, one write port and one
// registered read port on the same clock. A read of the address being written
// in the same cycle returns the old contents. Reads beyond DEPTH return 0.
module ml_frame_buf_dpram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic          raddr_ok;

    assign raddr_ok = ({1'b0, raddr} < DEPTH_L);

    // Write port: the caller has already range-checked and qualified we.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; cleared by reset so the output starts at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (raddr_ok) begin
            rdata <= mem[raddr[IW-1:0]];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/ml_frame_input_rx.sv
// ML-engine-side receiver of the camera-to-ML frame handshake. Advertises
// readiness, loads one frame into a local buffer, closes the handshake and
// holds the frame until the ML engine releases it.
// Optional feature: define ML_FRAME_CHECKSUM_EN to add o_checksum, the
// modulo-2^DW sum of all accepted writes of the frame.
//
// Handshake: o_rd_rdy is high in READY and LOAD. The upstream raises rd_req
// to start a frame, streams writes while rdy is high, then raises rd_done;
// rdy drops, the upstream clears rd_done, and the frame is presented.
module ml_frame_input_rx
    import ml_frame_pkg::*;
#(
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_arm,
    output logic          o_rd_rdy,
    input  logic          i_rd_req,
    input  logic          i_rd_done,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_din,
    output logic          o_frame_vld,
    input  logic          i_ml_release,
    input  logic [AW-1:0] i_ml_raddr,
    output logic [DW-1:0] o_ml_rdata,
    output logic [AW:0]   o_wr_count,
    output logic          o_err_short,
    output logic          o_err_oor,
    output logic          o_err_timeout,
`ifdef ML_FRAME_CHECKSUM_EN
    output logic [DW-1:0] o_checksum,
`endif
    output logic [2:0]    dbg_state
);

    localparam int          IW   = $clog2(FRAME_WORDS);
    localparam logic [AW:0] FW   = (AW+1)'(FRAME_WORDS);
    localparam logic [31:0] TO   = 32'(TIMEOUT);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [1:0]  req_sync;
    logic [1:0]  done_sync;
    logic        req_s;
    logic        done_s;
    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [31:0] idle_cnt;
    logic        in_range;
    logic        wr_acc;
    logic        arm_entry;
    logic        timeout_hit;
    logic [AW:0] count_nxt;

    assign req_s       = req_sync[1];
    assign done_s      = done_sync[1];
    assign in_range    = ({1'b0, i_waddr} < FW);
    assign wr_acc      = (state == LOAD) && i_we && in_range;
    assign arm_entry   = (state == IDLE) && i_arm;
    assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == TO);
    assign count_nxt   = (wr_acc && (o_wr_count != FW)) ? o_wr_count + ONE : o_wr_count;

    assign o_rd_rdy    = (state == READY) || (state == LOAD);
    assign o_frame_vld = (state == HOLD);
    assign dbg_state   = state;

    // Two-flop synchronisers for the asynchronous upstream flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_sync  <= '0;
            done_sync <= '0;
        end else begin
            req_sync  <= {req_sync[0], i_rd_req};
            done_sync <= {done_sync[0], i_rd_done};
        end
    end

    // Next-state logic; done wins over a timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_arm) state_nxt = READY;
            READY:   if (req_s) state_nxt = LOAD;
            LOAD: begin
                if (done_s)           state_nxt = DRAIN;
                else if (timeout_hit) state_nxt = ABORT;
            end
            DRAIN:   if (!done_s) state_nxt = HOLD;
            HOLD:    if (i_ml_release) state_nxt = IDLE;
            ABORT:   if (!done_s && !req_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Write counter, idle counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_wr_count    <= '0;
            idle_cnt      <= '0;
            o_err_short   <= 1'b0;
            o_err_oor     <= 1'b0;
            o_err_timeout <= 1'b0;
        end else begin
            if (arm_entry) begin
                o_err_short   <= 1'b0;
                o_err_oor     <= 1'b0;
                o_err_timeout <= 1'b0;
            end
            if (arm_entry || (state == READY)) begin
                o_wr_count <= '0;
                idle_cnt   <= '0;
            end
            if (state == LOAD) begin
                o_wr_count <= count_nxt;
                if (i_we)              idle_cnt <= '0;
                else if (TIMEOUT != 0) idle_cnt <= idle_cnt + 32'd1;
                if (i_we && !in_range) o_err_oor <= 1'b1;
                if (done_s) begin
                    if (count_nxt < FW) o_err_short <= 1'b1;
                end else if (timeout_hit) begin
                    o_err_timeout <= 1'b1;
                end
            end
        end
    end

`ifdef ML_FRAME_CHECKSUM_EN
    // Running sum of accepted writes; frozen outside LOAD.
    always_ff @(posedge clk) begin
        if (reset)          o_checksum <= '0;
        else if (arm_entry) o_checksum <= '0;
        else if (wr_acc)    o_checksum <= o_checksum + i_din;
    end
`endif

    ml_frame_buf_dpram #(
        .DEPTH (FRAME_WORDS),
        .AW    (AW),
        .DW    (DW),
        .IW    (IW)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc),
        .waddr (i_waddr[IW-1:0]),
        .wdata (i_din),
        .raddr (i_ml_raddr),
        .rdata (o_ml_rdata)
    );

endmodule

// File: tb/tb_ml_frame_input_rx.sv
// Directed testbench for ml_frame_input_rx (TIMEOUT overridden to 16).
// Define ML_FRAME_CHECKSUM_EN to also cover the checksum output.
module tb_ml_frame_input_rx;
    import ml_frame_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_arm;
    logic        o_rd_rdy;
    logic        i_rd_req;
    logic        i_rd_done;
    logic        i_we;
    logic [15:0] i_waddr;
    logic [15:0] i_din;
    logic        o_frame_vld;
    logic        i_ml_release;
    logic [15:0] i_ml_raddr;
    logic [15:0] o_ml_rdata;
    logic [16:0] o_wr_count;
    logic        o_err_short;
    logic        o_err_oor;
    logic        o_err_timeout;
`ifdef ML_FRAME_CHECKSUM_EN
    logic [15:0] o_checksum;
`endif
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    ml_frame_input_rx #(.TIMEOUT(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_arm         (i_arm),
        .o_rd_rdy      (o_rd_rdy),
        .i_rd_req      (i_rd_req),
        .i_rd_done     (i_rd_done),
        .i_we          (i_we),
        .i_waddr       (i_waddr),
        .i_din         (i_din),
        .o_frame_vld   (o_frame_vld),
        .i_ml_release  (i_ml_release),
        .i_ml_raddr    (i_ml_raddr),
        .o_ml_rdata    (o_ml_rdata),
        .o_wr_count    (o_wr_count),
        .o_err_short   (o_err_short),
        .o_err_oor     (o_err_oor),
        .o_err_timeout (o_err_timeout),
`ifdef ML_FRAME_CHECKSUM_EN
        .o_checksum    (o_checksum),
`endif
        .dbg_state     (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_word(input logic [15:0] a, input logic [15:0] d);
        i_we    = 1'b1;
        i_waddr = a;
        i_din   = d;
        tick();
        i_we    = 1'b0;
    endtask

    task automatic read_word(input logic [15:0] a, output logic [15:0] d);
        i_ml_raddr = a;
        tick();
        d = o_ml_rdata;
    endtask

    task automatic release_frame();
        i_ml_release = 1'b1;
        tick();
        i_ml_release = 1'b0;
    endtask

    // Waits for READY, pulses req and waits for LOAD; optionally keeps req high.
    task automatic start_frame(input bit hold_req);
        int n;
        n = 0;
        while (dbg_state != READY && n < 10) begin tick(); n++; end
        n_checks++;
        if (dbg_state !== READY || o_rd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ready: state=%0d rdy=%b, required state=%0d rdy=1", dbg_state, o_rd_rdy, READY);
        end
        i_rd_req = 1'b1;
        n = 0;
        while (dbg_state != LOAD && n < 10) begin tick(); n++; end
        n_checks++;
        if (dbg_state !== LOAD) begin
            n_fail++;
            $display("FAIL start_load: state=%0d, required %0d", dbg_state, LOAD);
        end
        if (!hold_req) i_rd_req = 1'b0;
    endtask

    // Raises done, waits for rdy to drop, clears done, waits for frame_vld.
    task automatic finish_frame(output int drop_cycles);
        int n;
        i_rd_done = 1'b1;
        n = 0;
        while (o_rd_rdy == 1'b1 && n < 10) begin tick(); n++; end
        drop_cycles = n;
        i_rd_done = 1'b0;
        n = 0;
        while (o_frame_vld != 1'b1 && n < 10) begin tick(); n++; end
        n_checks++;
        if (o_frame_vld !== 1'b1 || dbg_state !== HOLD) begin
            n_fail++;
            $display("FAIL finish_hold: frame_vld=%b state=%0d, required 1 / %0d", o_frame_vld, dbg_state, HOLD);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; i_arm = 1'b0; i_rd_req = 1'b0; i_rd_done = 1'b0;
        i_we = 1'b0; i_waddr = '0; i_din = '0; i_ml_release = 1'b0; i_ml_raddr = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({o_rd_rdy, o_frame_vld, o_err_short, o_err_oor, o_err_timeout} !== 5'b0
            || o_wr_count !== 17'd0 || o_ml_rdata !== 16'd0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b err=%b%b%b cnt=%0d rdata=%h state=%0d, required all 0 / IDLE",
                     o_rd_rdy, o_frame_vld, o_err_short, o_err_oor, o_err_timeout, o_wr_count, o_ml_rdata, dbg_state);
        end
        // Writes and releases outside LOAD are ignored and raise no flag.
        write_word(16'd2000, 16'h1111);
        release_frame();
        n_checks++;
        if (dbg_state !== IDLE || o_err_oor !== 1'b0 || o_wr_count !== 17'd0) begin
            n_fail++;
            $display("FAIL idle_ignore: state=%0d oor=%b cnt=%0d, required IDLE/0/0", dbg_state, o_err_oor, o_wr_count);
        end
    endtask

    task automatic test_full_frame();
        int drop;
        logic [15:0] got;
        logic [15:0] exp;
        i_arm = 1'b1;
        tick();
        n_checks++;
        if (dbg_state !== READY || o_rd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL arm_ready: state=%0d rdy=%b, required READY/1", dbg_state, o_rd_rdy);
        end
        start_frame(1'b0);
        for (int a = 0; a < 1024; a++) write_word(16'(a), 16'(a - 512));
        finish_frame(drop);
        n_checks++;
        if (drop < 1 || drop > 3) begin
            n_fail++;
            $display("FAIL full_rdy_drop: rdy dropped after %0d cycles, required 1..3", drop);
        end
        n_checks++;
        if (o_wr_count !== 17'd1024 || {o_err_short, o_err_oor, o_err_timeout} !== 3'b000) begin
            n_fail++;
            $display("FAIL full_status: cnt=%0d err=%b%b%b, required 1024 / 000", o_wr_count, o_err_short, o_err_oor, o_err_timeout);
        end
        // Writes in HOLD must not touch the buffer or the flags.
        write_word(16'd5, 16'h1234);
        write_word(16'd2000, 16'hBEEF);
        exp_q.push_back(16'hFE05);
        exp_q.push_back(16'hFE00);
        exp_q.push_back(16'h01FF);
        foreach (exp_q[i]) begin end
        read_word(16'd5, got);    exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL full_read5: got %h, required %h", got, exp); end
        read_word(16'd0, got);    exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL full_read0: got %h, required %h", got, exp); end
        read_word(16'd1023, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL full_read1023: got %h, required %h", got, exp); end
        n_checks++;
        if (o_err_oor !== 1'b0 || o_wr_count !== 17'd1024 || o_frame_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_ignore: oor=%b cnt=%0d vld=%b, required 0/1024/1", o_err_oor, o_wr_count, o_frame_vld);
        end
        release_frame();
    endtask

    task automatic test_short();
        int drop;
        int n;
        logic [15:0] got;
        start_frame(1'b0);
        for (int a = 0; a < 1000; a++) begin
            if (a == 7) begin
                i_ml_raddr = 16'd7;
                write_word(16'(a), 16'(a + 'h3000));
                got = o_ml_rdata;
                n_checks++;
                if (got !== 16'hFE07) begin
                    n_fail++;
                    $display("FAIL rdw_old: got %h, required %h", got, 16'hFE07);
                end
            end else begin
                write_word(16'(a), 16'(a + 'h3000));
            end
        end
        finish_frame(drop);
        n_checks++;
        if (o_err_short !== 1'b1 || o_wr_count !== 17'd1000 || o_frame_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL short_status: short=%b cnt=%0d vld=%b, required 1/1000/1", o_err_short, o_wr_count, o_frame_vld);
        end
        read_word(16'd7, got);
        n_checks++;
        if (got !== 16'h3007) begin n_fail++; $display("FAIL short_read7: got %h, required %h", got, 16'h3007); end
        read_word(16'd1010, got);
        n_checks++;
        if (got !== 16'h01F2) begin n_fail++; $display("FAIL short_read1010: got %h, required %h", got, 16'h01F2); end
        release_frame();
        n = 0;
        while (dbg_state != READY && n < 10) begin tick(); n++; end
        n_checks++;
        if (dbg_state !== READY || o_err_short !== 1'b0 || o_wr_count !== 17'd0) begin
            n_fail++;
            $display("FAIL short_rearm: state=%0d short=%b cnt=%0d, required READY/0/0", dbg_state, o_err_short, o_wr_count);
        end
    endtask

    task automatic test_oor();
        int drop;
        logic [15:0] got;
        start_frame(1'b0);
        for (int a = 0; a < 1024; a++) begin
            if (a == 512) write_word(16'd1024, 16'hDEAD);
            write_word(16'(a), 16'(a) ^ 16'h5A5A);
        end
        // Duplicates still count but the counter saturates.
        for (int a = 1; a < 5; a++) write_word(16'(a), 16'(a) ^ 16'h5A5A);
        finish_frame(drop);
        n_checks++;
        if (o_err_oor !== 1'b1 || o_err_short !== 1'b0 || o_wr_count !== 17'd1024) begin
            n_fail++;
            $display("FAIL oor_status: oor=%b short=%b cnt=%0d, required 1/0/1024", o_err_oor, o_err_short, o_wr_count);
        end
        read_word(16'd0, got);
        n_checks++;
        if (got !== 16'h5A5A) begin n_fail++; $display("FAIL oor_read0: got %h, required %h", got, 16'h5A5A); end
        read_word(16'd512, got);
        n_checks++;
        if (got !== 16'h585A) begin n_fail++; $display("FAIL oor_read512: got %h, required %h", got, 16'h585A); end
        release_frame();
    endtask

    task automatic test_timeout();
        int n;
        start_frame(1'b1);
        for (int a = 0; a < 3; a++) write_word(16'(a), 16'h7000);
        n = 0;
        while (o_err_timeout != 1'b1 && n < 40) begin tick(); n++; end
        n_checks++;
        if (o_err_timeout !== 1'b1 || n != 17) begin
            n_fail++;
            $display("FAIL timeout_latency: err=%b after %0d cycles, required 1 after 17", o_err_timeout, n);
        end
        repeat (3) tick();
        n_checks++;
        if (dbg_state !== ABORT || o_frame_vld !== 1'b0 || o_rd_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_hold: state=%0d vld=%b rdy=%b, required ABORT/0/0", dbg_state, o_frame_vld, o_rd_rdy);
        end
        i_arm = 1'b0;
        i_rd_req = 1'b0;
        n = 0;
        while (dbg_state != IDLE && n < 10) begin tick(); n++; end
        n_checks++;
        if (dbg_state !== IDLE || o_frame_vld !== 1'b0 || o_err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_exit: state=%0d vld=%b err=%b, required IDLE/0/1", dbg_state, o_frame_vld, o_err_timeout);
        end
        i_arm = 1'b1;
    endtask

    task automatic test_reset_mid();
        int drop;
        logic [15:0] got;
        start_frame(1'b0);
        for (int a = 0; a < 500; a++) write_word(16'(a), 16'(a + 'h1000));
        reset = 1'b1;
        tick();
        n_checks++;
        if ({o_rd_rdy, o_frame_vld, o_err_short, o_err_oor, o_err_timeout} !== 5'b0
            || o_wr_count !== 17'd0 || o_ml_rdata !== 16'd0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mid: rdy=%b vld=%b cnt=%0d rdata=%h state=%0d, required all 0 / IDLE",
                     o_rd_rdy, o_frame_vld, o_wr_count, o_ml_rdata, dbg_state);
        end
        reset = 1'b0;
        start_frame(1'b0);
        for (int a = 0; a < 1024; a++) write_word(16'(a), 16'(a + 1));
        finish_frame(drop);
        n_checks++;
        if (o_wr_count !== 17'd1024 || {o_err_short, o_err_oor, o_err_timeout} !== 3'b000) begin
            n_fail++;
            $display("FAIL clean_status: cnt=%0d err=%b%b%b, required 1024 / 000", o_wr_count, o_err_short, o_err_oor, o_err_timeout);
        end
        read_word(16'd1023, got);
        n_checks++;
        if (got !== 16'h0400) begin n_fail++; $display("FAIL clean_read1023: got %h, required %h", got, 16'h0400); end
`ifdef ML_FRAME_CHECKSUM_EN
        n_checks++;
        if (o_checksum !== 16'h0200) begin
            n_fail++;
            $display("FAIL checksum: got %h, required %h", o_checksum, 16'h0200);
        end
`endif
        release_frame();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_full_frame();
        test_short();
        test_oor();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
